serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
// Optional signed-overflow output Ovf is enabled with `define SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_br;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bnext;
  logic [WIDTH-1:0] w_d_shift;

  assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
  assign w_bnext   = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);
  assign w_d_shift = {w_d, r_d_sr[WIDTH-1:1]};
  assign busy      = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_d_sr <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= w_last;
      if (w_accept) begin
        r_a_sr <= A;
        r_b_sr <= B;
        r_br   <= Bin;
        r_d_sr <= '0;
        r_cnt  <= CW'(WIDTH);
      end else if (r_state == S_RUN) begin
        r_a_sr <= r_a_sr >> 1;
        r_b_sr <= r_b_sr >> 1;
        r_br   <= w_bnext;
        r_d_sr <= w_d_shift;
        r_cnt  <= r_cnt - 1'b1;
      end
      // Final bit bypasses d_sr so the result lands on the same edge as done.
      if (w_last) begin
        Diff <= w_d_shift;
        Bout <= w_bnext;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
      end
      if (w_last) Ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus hand-written multi-cycle sequences.
module tb_serial_subtractor;

  localparam int W = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         Ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .Diff (Diff),
    .Bout (Bout),
    .busy (busy),
`ifdef SERIAL_SUB_OVF_EN
    .Ovf  (Ovf),
`endif
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int           k;
    logic         bad;
    logic [W-1:0] prev;
    prev = Diff;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    k = 0; bad = 1'b0;
    while (!done && k < 40) begin
      if (busy !== 1'b1 || Diff !== prev) bad = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_latency"}, k, W);
    chk({name, "_busy_stable"}, 32'(bad), 0);
    chk({name, "_diff"}, 32'(Diff), 32'(ed));
    chk({name, "_bout"}, 32'(Bout), 32'(eb));
    chk({name, "_busy_at_done"}, 32'(busy), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk({name, "_ovf"}, 32'(Ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected X in ovf expectation");
`endif
    @(posedge clk); #1;
    chk({name, "_done_one_cycle"}, 32'(done), 0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  initial begin
    int k;
    int nd;

    vecs[0]  = '{"v500_123",  10'd500,  10'd123,  1'b0, 10'd377,  1'b0, 1'b0};
    vecs[1]  = '{"v5_9",      10'd5,    10'd9,    1'b0, 10'd1020, 1'b1, 1'b0};
    vecs[2]  = '{"v0_0_b1",   10'd0,    10'd0,    1'b1, 10'd1023, 1'b1, 1'b0};
    vecs[3]  = '{"v1023_1",   10'd1023, 10'd1,    1'b0, 10'd1022, 1'b0, 1'b0};
    vecs[4]  = '{"v300_100",  10'd300,  10'd100,  1'b0, 10'd200,  1'b0, 1'b0};
    vecs[5]  = '{"v511_m1",   10'd511,  10'd1023, 1'b0, 10'd512,  1'b1, 1'b1};
    vecs[6]  = '{"v100_30",   10'd100,  10'd30,   1'b0, 10'd70,   1'b0, 1'b0};
    vecs[7]  = '{"v0_m1_b1",  10'd0,    10'd1023, 1'b1, 10'd0,    1'b1, 1'b0};
    vecs[8]  = '{"vm1_m1_b1", 10'd1023, 10'd1023, 1'b1, 10'd1023, 1'b1, 1'b0};
    vecs[9]  = '{"vmin_1",    10'd512,  10'd1,    1'b0, 10'd511,  1'b0, 1'b1};
    vecs[10] = '{"v50_200",   10'd50,   10'd200,  1'b0, 10'd874,  1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #3;
    chk("reset_diff", 32'(Diff), 0);
    chk("reset_bout", 32'(Bout), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ov);

    // start pulsed while busy must be ignored
    @(negedge clk);
    A = 10'd300; B = 10'd100; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    A = 10'd7; B = 10'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 4;
    while (!done && k < 40) begin @(posedge clk); #1; k++; end
    chk("ignore_latency", k, W);
    chk("ignore_diff", 32'(Diff), 200);
    count_done(15, nd);
    chk("ignore_no_extra_done", nd, 0);
    chk("ignore_diff_held", 32'(Diff), 200);

    // start held high: done every WIDTH+1 cycles
    @(negedge clk);
    A = 10'd1023; B = 10'd1; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        chk("held_done_cycle", c, 10 + 11 * (nd - 1));
        chk("held_diff", 32'(Diff), 1022);
        chk("held_bout", 32'(Bout), 0);
      end
    end
    start = 1'b0;
    chk("held_done_count", nd, 3);
    count_done(15, nd);
    chk("held_idle_after", nd, 0);

    // asynchronous reset mid-run
    @(negedge clk);
    A = 10'd200; B = 10'd50; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_diff", 32'(Diff), 0);
    chk("rst_mid_bout", 32'(Bout), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_mid_ovf", 32'(Ovf), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    count_done(15, nd);
    chk("rst_no_done", nd, 0);
    run_op("after_rst", 10'd50, 10'd200, 1'b0, 10'd874, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang, expected finish");
    $fatal(1);
  end

endmodule
